// File: rtl/pc_ras_unit.sv
// pc_ras_unit: program counter with a return-address stack (RAS).
// Next-PC operations are SEQ, JUMP, BRANCH (signed offset), CALL (push pc+STEP)
// and RET (pop). The stack is a ring buffer indexed by a top pointer.
// A sticky ras_err flag records stack overflow and underflow.
// Build option: define PC_RAS_TRAP_EN to redirect overflow and underflow to
// TRAP_VEC with a one-cycle trap pulse. Without it, CALL on a full stack
// overwrites the oldest entry, RET on an empty stack falls through to pc+STEP,
// and trap is tied low.
module pc_ras_unit #(
    parameter int              WIDTH     = 16,
    parameter int              STEP      = 1,
    parameter int              RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(16'hFFF0)
) (
    input  logic                             CLK,
    input  logic                             reset,
    input  logic                             pc_write,
    input  logic [2:0]                       op,
    input  logic [WIDTH-1:0]                 target,
    input  logic                             err_clr,
    output logic [WIDTH-1:0]                 pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_depth,
    output logic                             ras_full,
    output logic                             ras_empty,
    output logic                             ras_err,
    output logic                             trap
);

    localparam int DW = $clog2(RAS_DEPTH + 1);
    localparam int PW = $clog2(RAS_DEPTH);

    localparam logic [2:0] OP_JUMP   = 3'b001;
    localparam logic [2:0] OP_BRANCH = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;

`ifdef PC_RAS_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]    top;        // next slot to write; top-1 holds the newest entry
    logic [PW-1:0]    top_inc;
    logic [PW-1:0]    top_dec;
    logic [PW-1:0]    top_next;
    logic [DW-1:0]    depth_next;
    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pop_val;
    logic             push;
    logic             pop;
    logic             err_evt;

    assign ras_full  = (ras_depth == DW'(RAS_DEPTH));
    assign ras_empty = (ras_depth == '0);
    assign pc_seq    = pc + WIDTH'(STEP);

    // The ring wraps explicitly, so RAS_DEPTH need not be a power of two.
    assign top_inc = (top == PW'(RAS_DEPTH - 1)) ? '0 : top + PW'(1);
    assign top_dec = (top == '0) ? PW'(RAS_DEPTH - 1) : top - PW'(1);
    assign pop_val = stack[top_dec];

    // Decode the operation into the next PC, the stack action and any error.
    // NOTE: each output gets a default before the case so that no latch is inferred.
    always_comb begin
        pc_next    = pc_seq;
        push       = 1'b0;
        pop        = 1'b0;
        err_evt    = 1'b0;
        top_next   = top;
        depth_next = ras_depth;
        case (op)
            OP_JUMP:   pc_next = target;
            OP_BRANCH: pc_next = pc + target;   // modular add is the signed add
            OP_CALL: begin
                if (ras_full && TRAP_EN) begin
                    pc_next = TRAP_VEC;
                    err_evt = 1'b1;
                end else begin
                    // On a full ring, top already points at the oldest entry,
                    // so a plain push overwrites that entry.
                    push    = 1'b1;
                    pc_next = target;
                    err_evt = ras_full;
                end
            end
            OP_RET: begin
                if (ras_empty) begin
                    pc_next = TRAP_EN ? TRAP_VEC : pc_seq;
                    err_evt = 1'b1;
                end else begin
                    pop     = 1'b1;
                    pc_next = pop_val;
                end
            end
            default: ;                          // SEQ and the unused encodings
        endcase
        if (push) begin
            top_next = top_inc;
            if (!ras_full) depth_next = ras_depth + DW'(1);
        end
        if (pop) begin
            top_next   = top_dec;
            depth_next = ras_depth - DW'(1);
        end
    end

    // PC and stack bookkeeping. Reset overrides everything; pc_write gates updates.
    // NOTE: sequential state uses non-blocking assignments so that every register
    // samples the values from before the edge.
    always_ff @(posedge CLK) begin
        if (reset) begin
            pc        <= RESET_PC;
            top       <= '0;
            ras_depth <= '0;
        end else if (pc_write) begin
            pc        <= pc_next;
            top       <= top_next;
            ras_depth <= depth_next;
        end
    end

    // Stack storage.
    // NOTE: entries have no reset; ras_depth alone says which entries are valid.
    always_ff @(posedge CLK) begin
        if (!reset && pc_write && push) stack[top] <= pc_seq;
    end

    // Sticky error: a new error wins over a clear in the same cycle.
    always_ff @(posedge CLK) begin
        if (reset)                     ras_err <= 1'b0;
        else if (pc_write && err_evt)  ras_err <= 1'b1;
        else if (err_clr)              ras_err <= 1'b0;
    end

`ifdef PC_RAS_TRAP_EN
    // One-cycle trap pulse on the edge that takes an overflow or underflow.
    always_ff @(posedge CLK) begin
        if (reset) trap <= 1'b0;
        else       trap <= pc_write && err_evt;
    end
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_pc_ras_unit.sv
// Self-checking bench for pc_ras_unit with default parameters.
// A queue-based reference model is compared against the DUT on every cycle.
// Literal checks pin the directed scenarios. The bench honours PC_RAS_TRAP_EN
// when the same macro is defined for the build.
module tb_pc_ras_unit;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        pc_write = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [15:0] target = '0;
    logic        err_clr = 1'b0;
    logic [15:0] pc;
    logic [2:0]  ras_depth;
    logic        ras_full;
    logic        ras_empty;
    logic        ras_err;
    logic        trap;

    pc_ras_unit dut (
        .CLK       (CLK),
        .reset     (reset),
        .pc_write  (pc_write),
        .op        (op),
        .target    (target),
        .err_clr   (err_clr),
        .pc        (pc),
        .ras_depth (ras_depth),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .ras_err   (ras_err),
        .trap      (trap)
    );

    always #5 CLK = ~CLK;

`ifdef PC_RAS_TRAP_EN
    localparam bit TB_TRAP = 1'b1;
`else
    localparam bit TB_TRAP = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: the stack is a queue of return addresses, newest at the back.
    logic [15:0] ras_q[$];
    logic [15:0] m_pc = '0;
    logic        m_err = 1'b0;
    logic        m_trap = 1'b0;
    logic        model_valid = 1'b0;

    task automatic model_update(input logic rst, input logic pw, input logic [2:0] o,
                                input logic [15:0] t, input logic ec);
        logic new_err;
        new_err = 1'b0;
        if (rst) begin
            m_pc = 16'h0000;
            ras_q.delete();
            m_err = 1'b0;
            m_trap = 1'b0;
            return;
        end
        m_trap = 1'b0;
        if (pw) begin
            case (o)
                3'd1: m_pc = t;
                3'd2: m_pc = m_pc + t;
                3'd3: begin
                    if (ras_q.size() == 4) begin
                        new_err = 1'b1;
                        if (TB_TRAP) begin
                            m_pc = 16'hFFF0;
                            m_trap = 1'b1;
                        end else begin
                            void'(ras_q.pop_front());
                            ras_q.push_back(m_pc + 16'd1);
                            m_pc = t;
                        end
                    end else begin
                        ras_q.push_back(m_pc + 16'd1);
                        m_pc = t;
                    end
                end
                3'd4: begin
                    if (ras_q.size() == 0) begin
                        new_err = 1'b1;
                        if (TB_TRAP) begin
                            m_pc = 16'hFFF0;
                            m_trap = 1'b1;
                        end else begin
                            m_pc = m_pc + 16'd1;
                        end
                    end else begin
                        m_pc = ras_q.pop_back();
                    end
                end
                default: m_pc = m_pc + 16'd1;
            endcase
        end
        if (new_err)     m_err = 1'b1;
        else if (ec)     m_err = 1'b0;
    endtask

    // Single compare process: DUT outputs against the model, away from the active edge.
    always @(negedge CLK) begin
        if (model_valid) begin
            check("pc",        pc,        m_pc);
            check("ras_depth", ras_depth, ras_q.size());
            check("ras_full",  ras_full,  ras_q.size() == 4);
            check("ras_empty", ras_empty, ras_q.size() == 0);
            check("ras_err",   ras_err,   m_err);
            check("trap",      trap,      m_trap);
        end
    end

    // Apply one cycle of inputs, advance the model at the edge, and return at the next negedge.
    task automatic step(input logic rst, input logic pw, input logic [2:0] o,
                        input logic [15:0] t, input logic ec);
        reset = rst; pc_write = pw; op = o; target = t; err_clr = ec;
        @(posedge CLK);
        model_update(rst, pw, o, t, ec);
        model_valid = 1'b1;
        @(negedge CLK);
    endtask

    localparam logic [2:0] SEQ = 3'd0, JMP = 3'd1, BR = 3'd2, CALL = 3'd3, RET = 3'd4;

    initial begin
        @(negedge CLK);

        // Reset, then three SEQ cycles.
        step(1, 1, SEQ, 16'h0, 0);
        check("rst_pc", pc, 16'h0000);
        check("rst_empty", ras_empty, 1);
        for (int i = 1; i <= 3; i++) begin
            step(0, 1, SEQ, 16'h0, 0);
            check("seq_pc", pc, i);
        end
        check("seq_empty", ras_empty, 1);

        // Negative branch, and the PC wrap.
        step(0, 1, JMP, 16'h0010, 0);
        step(0, 1, BR,  16'hFFFC, 0);
        check("branch_neg", pc, 16'h000C);
        step(0, 1, JMP, 16'hFFFF, 0);
        step(0, 1, SEQ, 16'h0000, 0);
        check("wrap_pc", pc, 16'h0000);
        check("wrap_err", ras_err, 0);
        step(0, 1, 3'd5, 16'h0, 0);
        step(0, 1, 3'd7, 16'h0, 0);
        check("op_alias_seq", pc, 16'h0002);

        // CALL, SEQ, SEQ, RET.
        step(0, 1, JMP,  16'h0005, 0);
        step(0, 1, CALL, 16'h0100, 0);
        check("call_pc", pc, 16'h0100);
        check("call_depth", ras_depth, 1);
        step(0, 1, SEQ, 16'h0, 0);
        step(0, 1, SEQ, 16'h0, 0);
        check("seq2_pc", pc, 16'h0102);
        step(0, 1, RET, 16'h0, 0);
        check("ret_pc", pc, 16'h0006);
        check("ret_depth", ras_depth, 0);

        // Five nested CALLs into a 4-entry stack, then four RETs.
        step(1, 0, SEQ, 16'h0, 0);
        step(0, 1, JMP, 16'h1000, 0);
        for (int i = 2; i <= 6; i++) step(0, 1, CALL, 16'(i) << 12, 0);
        check("ovf_err", ras_err, 1);
        check("ovf_depth", ras_depth, 4);
        if (TB_TRAP) begin
            check("ovf_trap_pc", pc, 16'hFFF0);
            check("ovf_trap_hi", trap, 1);
            step(0, 1, RET, 16'h0, 0);
            check("ovf_trap_lo", trap, 0);
            check("ovf_ret1", pc, 16'h4001);
        end else begin
            check("ovf_pc", pc, 16'h6000);
            for (int i = 5; i >= 2; i--) begin
                step(0, 1, RET, 16'h0, 0);
                check("ovf_ret", pc, (16'(i) << 12) | 16'h0001);
            end
            check("ovf_drained", ras_empty, 1);
        end

        // Underflow, the error clear, and a clear colliding with a new error.
        step(1, 0, SEQ, 16'h0, 0);
        step(0, 1, JMP, 16'h0020, 0);
        step(0, 1, RET, 16'h0, 0);
        check("unf_pc", pc, TB_TRAP ? 16'hFFF0 : 16'h0021);
        check("unf_err", ras_err, 1);
        step(0, 0, SEQ, 16'h0, 1);
        check("clr_no_write", ras_err, 0);
        step(0, 1, RET, 16'h0, 1);
        check("clr_vs_err", ras_err, 1);

        // Hold with pc_write=0, and reset taking priority over CALL.
        step(0, 1, JMP,  16'h0040, 0);
        step(0, 1, CALL, 16'h0200, 0);
        step(0, 0, CALL, 16'h0300, 0);
        check("hold_pc", pc, 16'h0200);
        check("hold_depth", ras_depth, 1);
        step(1, 1, CALL, 16'h0300, 0);
        check("rst_call_pc", pc, 16'h0000);
        check("rst_call_depth", ras_depth, 0);
        step(0, 1, RET, 16'h0, 0);
        check("rst_then_ret_err", ras_err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
